mem_arbiter: RTL and testbench

- Shares the processor's single-port unified memory between two requesters.
  - The multi-cycle control/datapath (instruction fetch and lw/sw).
  - The program loader/debug port.
- Serialises transactions through a small FSM, handles fixed memory read latency, and returns one-cycle acks.
- Sits between the control unit's memory-request signals and the memory macro.

---
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/loader requesters, the arbiter and the memory macro.
// With ARB_LD_LOCK_EN defined, the bundle also carries the loader lock input ld_lock.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ack;
    logic [DATA_W-1:0] ld_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              owner;
`ifdef ARB_LD_LOCK_EN
    logic              ld_lock;
`endif

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_ack, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, owner,
        input  mem_rdata
`ifdef ARB_LD_LOCK_EN
        , input ld_lock
`endif
    );

    // Requester / memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_ack, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, owner,
        output mem_rdata
`ifdef ARB_LD_LOCK_EN
        , output ld_lock
`endif
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and the loader.
// Optional ARB_LD_LOCK_EN: bus.ld_lock holds the CPU off and hands every decision to the loader.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic         CLK,
    input  logic         Reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t            state_r;
    logic              last_owner_r;
    logic              owner_r;
    logic              we_r;
    logic [2:0]        cnt_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              cpu_ack_r;
    logic              ld_ack_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] ld_rdata_r;
    logic              busy_r;

    logic              cpu_ok_s;
    logic              ld_ok_s;
    logic              grant_s;
    logic              grant_ld_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    // Qualify requests and pick the winner of the next IDLE decision
    always_comb begin
`ifdef ARB_LD_LOCK_EN
        if (bus.ld_lock) begin
            cpu_ok_s = 1'b0;
        end else begin
            cpu_ok_s = bus.cpu_req;
        end
`else
        cpu_ok_s = bus.cpu_req;
`endif
        ld_ok_s = bus.ld_req;
        grant_s = cpu_ok_s | ld_ok_s;
        if (cpu_ok_s && ld_ok_s) begin
            grant_ld_s = ~last_owner_r;
        end else begin
            grant_ld_s = ld_ok_s;
        end
        if (grant_ld_s) begin
            sel_we_s    = bus.ld_we;
            sel_addr_s  = bus.ld_addr;
            sel_wdata_s = bus.ld_wdata;
        end else begin
            sel_we_s    = bus.cpu_we;
            sel_addr_s  = bus.cpu_addr;
            sel_wdata_s = bus.cpu_wdata;
        end
    end

    // Transaction sequencer; every bus output is a register updated here
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r      <= IDLE;
            last_owner_r <= 1'b1;
            owner_r      <= 1'b0;
            we_r         <= 1'b0;
            cnt_r        <= 3'd0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            cpu_ack_r    <= 1'b0;
            ld_ack_r     <= 1'b0;
            cpu_rdata_r  <= {DATA_W{1'b0}};
            ld_rdata_r   <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r     <= ISSUE;
                        owner_r     <= grant_ld_s;
                        we_r        <= sel_we_s;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= sel_we_s;
                        mem_addr_r  <= sel_addr_s;
                        mem_wdata_r <= sel_wdata_s;
                        busy_r      <= 1'b1;
                    end
                end
                ISSUE: begin
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    if (we_r) begin
                        state_r <= DONE;
                        if (owner_r) ld_ack_r <= 1'b1;
                        else         cpu_ack_r <= 1'b1;
                    end else begin
                        cnt_r   <= LAT_INIT;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    // Data is valid in the last WAIT cycle: MEM_LAT cycles after ISSUE
                    if (cnt_r <= 3'd1) begin
                        state_r <= DONE;
                        if (owner_r) begin
                            ld_rdata_r <= bus.mem_rdata;
                            ld_ack_r   <= 1'b1;
                        end else begin
                            cpu_rdata_r <= bus.mem_rdata;
                            cpu_ack_r   <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                DONE: begin
                    cpu_ack_r    <= 1'b0;
                    ld_ack_r     <= 1'b0;
                    busy_r       <= 1'b0;
                    last_owner_r <= owner_r;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    mem_en_r  <= 1'b0;
                    mem_we_r  <= 1'b0;
                    cpu_ack_r <= 1'b0;
                    ld_ack_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.cpu_ack   = cpu_ack_r;
    assign bus.ld_ack    = ld_ack_r;
    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.ld_rdata  = ld_rdata_r;
    assign bus.busy      = busy_r;
    assign bus.owner     = owner_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: a transaction-level model predicts every
// grant, memory command, ack cycle and read value; a monitor compares the DUT each cycle.
module tb_mem_arbiter;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 3;

    typedef struct {
        bit          own;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          mem_cyc;
        int          ack_cyc;
    } txn_t;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    txn_t        sbq[$];
    int          ack_log[$];
    bit          granted[2];
    logic [15:0] ref_mem[16];
    logic [15:0] mem_arr[16];
    logic [15:0] exp_rd[2];
    bit          exp_own;
    logic [15:0] rd_data;
    int          rd_due = -1;
    int          lock_viol = 0;

    initial forever #5 CLK = ~CLK;
    initial forever begin @(posedge CLK); cyc++; end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Memory macro: read data is presented only in the cycle LAT after the access
    initial begin
        bus.mem_rdata = 16'h0000;
        forever begin
            @(posedge CLK);
            #1;
            bus.mem_rdata = (cyc == rd_due) ? rd_data : 16'($urandom);
        end
    end
    initial forever begin
        @(negedge CLK);
        if (!Reset && bus.mem_en) begin
            if (bus.mem_we) begin
                mem_arr[bus.mem_addr[3:0]] = bus.mem_wdata;
            end else begin
                rd_data = mem_arr[bus.mem_addr[3:0]];
                rd_due  = cyc + LAT;
            end
        end
    end

    // Reference model: one decision per free cycle, round robin, fixed latencies
    initial begin : model
        bit   m_last;
        int   t_free;
        bit   c_ok;
        bit   l_ok;
        txn_t t;
        m_last = 1'b1;
        t_free = 0;
        forever begin
            @(negedge CLK);
            if (Reset) begin
                m_last = 1'b1;
                t_free = 0;
                sbq.delete();
            end else if (cyc >= t_free) begin
                c_ok = bus.cpu_req;
                l_ok = bus.ld_req;
`ifdef ARB_LD_LOCK_EN
                if (bus.ld_lock) c_ok = 1'b0;
`endif
                if (c_ok || l_ok) begin
                    t.own     = (c_ok && l_ok) ? !m_last : l_ok;
                    t.we      = t.own ? bus.ld_we    : bus.cpu_we;
                    t.addr    = t.own ? bus.ld_addr  : bus.cpu_addr;
                    t.wdata   = t.own ? bus.ld_wdata : bus.cpu_wdata;
                    t.mem_cyc = cyc + 1;
                    t.ack_cyc = cyc + 2 + (t.we ? 0 : LAT);
                    t.rdata   = ref_mem[t.addr[3:0]];
                    if (t.we) ref_mem[t.addr[3:0]] = t.wdata;
                    m_last = t.own;
                    t_free = t.ack_cyc + 1;
                    sbq.push_back(t);
                    granted[t.own] = 1'b1;
                end
            end
        end
    end

    // Monitor: compare every DUT output against the head of the scoreboard
    initial begin : monitor
        bit   have;
        bit   e_men;
        bit   e_ack;
        txn_t f;
        forever begin
            @(negedge CLK);
            if (Reset) begin
                exp_rd[0] = 16'h0000;
                exp_rd[1] = 16'h0000;
                exp_own   = 1'b0;
                chk("rst_ctrl", {bus.mem_en, bus.mem_we, bus.cpu_ack, bus.ld_ack, bus.busy, bus.owner}, 64'd0);
                chk("rst_rdata", {bus.cpu_rdata, bus.ld_rdata}, 64'd0);
                chk("rst_membus", {bus.mem_addr, bus.mem_wdata}, 64'd0);
            end else begin
                have  = sbq.size() > 0;
                if (have) f = sbq[0];
                e_men = have && (f.mem_cyc == cyc);
                e_ack = have && (f.ack_cyc == cyc);
                if (e_men) exp_own = f.own;
                if (e_ack && !f.we) exp_rd[f.own] = f.rdata;
                chk("mem_en", bus.mem_en, e_men);
                if (e_men) chk("mem_cmd", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {f.we, f.addr, f.wdata});
                chk("cpu_ack", bus.cpu_ack, e_ack && !f.own);
                chk("ld_ack", bus.ld_ack, e_ack && f.own);
                chk("busy", bus.busy, have && (cyc >= f.mem_cyc));
                chk("owner", bus.owner, exp_own);
                chk("cpu_rdata", bus.cpu_rdata, exp_rd[0]);
                chk("ld_rdata", bus.ld_rdata, exp_rd[1]);
                if (bus.cpu_ack) ack_log.push_back(0);
                if (bus.ld_ack) ack_log.push_back(1);
`ifdef ARB_LD_LOCK_EN
                if (bus.ld_lock && bus.cpu_ack) lock_viol++;
`endif
                if (e_ack) void'(sbq.pop_front());
            end
        end
    end

    task automatic drive(input bit who, input logic r, input logic we, input logic [15:0] a, input logic [15:0] d);
        if (who) begin
            bus.ld_req = r; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d;
        end else begin
            bus.cpu_req = r; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end
    endtask

    function automatic logic ackv(input bit who);
        return who ? bus.ld_ack : bus.cpu_ack;
    endfunction

    // One handshake; returns in the cycle after ack with req still high only if keep is set
    task automatic txn(input bit who, input logic we, input logic [15:0] a, input logic [15:0] d, input bit keep);
        int n;
        n = 0;
        granted[who] = 1'b0;
        drive(who, 1'b1, we, a, d);
        while (!granted[who] && n < 400) begin step(); n++; end
        chk("grant_wait", granted[who], 1'b1);
        if (!granted[who]) begin
            drive(who, 1'b0, we, a, d);
            return;
        end
        if ($urandom_range(3, 0) == 0) drive(who, 1'b0, we, a, d);
        n = 0;
        do begin @(negedge CLK); n++; end while (!ackv(who) && n < 400);
        chk("ack_wait", ackv(who), 1'b1);
        step();
        if (!keep) drive(who, 1'b0, we, a, d);
    endtask

    task automatic requester(input bit who, input int n, input int wr_pct, input int gap_max);
        int          gap;
        int          ngap;
        logic        we;
        logic [15:0] a;
        logic [15:0] d;
        gap = $urandom_range(gap_max, 0);
        for (int k = 0; k < n; k++) begin
            repeat (gap) step();
            ngap = $urandom_range(gap_max, 0);
            we   = ($urandom_range(99, 0) < wr_pct);
            a    = 16'($urandom);
            d    = 16'($urandom);
            txn(who, we, a, d, (k < n - 1) && (ngap == 0));
            gap = ngap;
        end
    endtask

    initial begin : main
        int n;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
`ifdef ARB_LD_LOCK_EN
        bus.ld_lock = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 16'h0000;
            mem_arr[i] = 16'h0000;
        end
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b0;

        // Both requesters held high from reset: grants must alternate starting with the CPU
        fork
            requester(1'b0, 2, 100, 0);
            requester(1'b1, 2, 100, 0);
        join
        chk("rr_count", ack_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("rr_order", ack_log[i], i % 2);

        // CPU write then loader read of the same word
        txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        chk("ld_read_beef", bus.ld_rdata, 16'hBEEF);

        // Random mixed traffic with gaps, back-to-back requests and early req drops
        fork
            requester(1'b0, 40, 50, 3);
            requester(1'b1, 40, 50, 3);
        join

        // Reset during the WAIT phase of a loader read
        n = 0;
        granted[1] = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 16'h0123, 16'h0000);
        while (!granted[1] && n < 50) begin step(); n++; end
        step();
        Reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'h0123, 16'h0000);
        @(negedge CLK);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_ld_ack", bus.ld_ack, 1'b0);
        step();
        Reset = 1'b0;
        ack_log.delete();
        fork
            txn(1'b0, 1'b1, 16'h0040, 16'h1111, 1'b0);
            txn(1'b1, 1'b1, 16'h0050, 16'h2222, 1'b0);
        join
        chk("post_rst_count", ack_log.size(), 2);
        if (ack_log.size() > 0) chk("post_rst_first", ack_log[0], 0);

`ifdef ARB_LD_LOCK_EN
        // Loader lock: CPU held off until the lock drops
        bus.ld_lock = 1'b1;
        fork
            requester(1'b0, 3, 50, 2);
            requester(1'b1, 6, 50, 4);
            begin repeat (80) step(); bus.ld_lock = 1'b0; end
        join
        chk("lock_cpu_acks", lock_viol, 0);
`endif

        repeat (5) step();
        chk("sb_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog at cycle %0d: got no finish, required finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
